mem_arbiter: RTL and testbench

//  Arbitrates the single-port instruction/data memory between the CPU (fetch/execute

---
 rtl/mem_arbiter.sv | 119 +++++++++++
 tb/tb_mem_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between the CPU and a loader/debug port.
// The CPU has priority, and a starvation counter guarantees that the loader makes progress.
module mem_arbiter #(
   parameter int AWIDTH       = 5,
   parameter int DWIDTH       = 8,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst_,
   input  logic              cpu_req,
   input  logic              cpu_wr,
   input  logic [AWIDTH-1:0] cpu_addr,
   input  logic [DWIDTH-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic [DWIDTH-1:0] cpu_rdata,
   output logic              cpu_rvalid,
   output logic              cpu_stall,
   input  logic              ldr_req,
   input  logic              ldr_wr,
   input  logic [AWIDTH-1:0] ldr_addr,
   input  logic [DWIDTH-1:0] ldr_wdata,
   output logic              ldr_gnt,
   output logic [DWIDTH-1:0] ldr_rdata,
   output logic              ldr_rvalid,
   output logic [AWIDTH-1:0] mem_addr,
   output logic [DWIDTH-1:0] mem_wdata,
   output logic              mem_rd,
   output logic              mem_wr,
   input  logic [DWIDTH-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, GNT_CPU, GNT_LDR} state_t;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   state_t            state, state_next;
   logic [3:0]        starve_cnt, starve_next;
   logic              wr_q;
   logic              owner_q;       // 1 = loader owns the access in flight
   logic              cpu_rv_q, ldr_rv_q;
   logic [DWIDTH-1:0] cpu_hold_q, ldr_hold_q;

   // NOTE: every variable gets a default before any branch, so no latch can be inferred.
   always_comb begin
      state_next  = IDLE;
      starve_next = starve_cnt;
      cpu_gnt     = 1'b0;
      ldr_gnt     = 1'b0;
      mem_rd      = 1'b0;
      mem_wr      = 1'b0;

      if (cpu_req && ldr_req)
         state_next = (starve_cnt == LIMIT) ? GNT_LDR : GNT_CPU;
      else if (cpu_req)
         state_next = GNT_CPU;
      else if (ldr_req)
         state_next = GNT_LDR;

      if (!ldr_req || state_next == GNT_LDR)
         starve_next = 4'd0;
      else if (state_next == GNT_CPU && starve_cnt < LIMIT)
         starve_next = starve_cnt + 4'd1;

      case (state)
         GNT_CPU: cpu_gnt = 1'b1;
         GNT_LDR: ldr_gnt = 1'b1;
         default: ;
      endcase

      if (state != IDLE) begin
         mem_rd = ~wr_q;
         mem_wr = wr_q;
      end
   end

   // Read data passes straight through in the response cycle; otherwise the port keeps its last value.
   assign cpu_rvalid = cpu_rv_q;
   assign ldr_rvalid = ldr_rv_q;
   assign cpu_rdata  = cpu_rv_q ? mem_rdata : cpu_hold_q;
   assign ldr_rdata  = ldr_rv_q ? mem_rdata : ldr_hold_q;
   assign cpu_stall  = cpu_req & ~cpu_gnt;

   // NOTE: reset is synchronous and sampled only at the clock edge; all state uses non-blocking updates.
   always_ff @(posedge clk) begin
      if (!rst_) begin
         state      <= IDLE;
         starve_cnt <= 4'd0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         wr_q       <= 1'b0;
         owner_q    <= 1'b0;
         cpu_rv_q   <= 1'b0;
         ldr_rv_q   <= 1'b0;
         cpu_hold_q <= '0;
         ldr_hold_q <= '0;
      end else begin
         state      <= state_next;
         starve_cnt <= starve_next;
         cpu_rv_q   <= (state != IDLE) && !wr_q && !owner_q;
         ldr_rv_q   <= (state != IDLE) && !wr_q && owner_q;

         if (cpu_rv_q) cpu_hold_q <= mem_rdata;
         if (ldr_rv_q) ldr_hold_q <= mem_rdata;

         if (state_next == GNT_CPU) begin
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
            wr_q      <= cpu_wr;
            owner_q   <= 1'b0;
         end else if (state_next == GNT_LDR) begin
            mem_addr  <= ldr_addr;
            mem_wdata <= ldr_wdata;
            wr_q      <= ldr_wr;
            owner_q   <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal expectations,
// followed by randomized traffic compared every cycle against a transaction-level model.
module tb_mem_arbiter;

   localparam int AW    = 5;
   localparam int DW    = 8;
   localparam int LIMIT = 4;

   logic          clk = 1'b0;
   logic          rst_ = 1'b0;
   logic          cpu_req = 1'b0, cpu_wr = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [DW-1:0] cpu_wdata = '0;
   logic          ldr_req = 1'b0, ldr_wr = 1'b0;
   logic [AW-1:0] ldr_addr = '0;
   logic [DW-1:0] ldr_wdata = '0;
   logic          cpu_gnt, cpu_rvalid, cpu_stall, ldr_gnt, ldr_rvalid;
   logic [DW-1:0] cpu_rdata, ldr_rdata, mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic [AW-1:0] mem_addr;
   logic          mem_rd, mem_wr;

   int checks = 0;
   int errors = 0;

   mem_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst_(rst_),
      .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .cpu_stall(cpu_stall),
      .ldr_req(ldr_req), .ldr_wr(ldr_wr), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
      .ldr_gnt(ldr_gnt), .ldr_rdata(ldr_rdata), .ldr_rvalid(ldr_rvalid),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] init_val(input int i);
      return (i == 5) ? 8'hA7 : 8'(i * 29 + 7);
   endfunction

   // Memory attached to the arbiter: writes commit at the edge, read data appears one cycle after mem_rd.
   logic [DW-1:0] mem [32];
   logic          started = 1'b0;

   always @(posedge clk) begin
      if (!started) begin
         for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
      end else begin
         if (mem_wr === 1'b1) mem[mem_addr] <= mem_wdata;
         if (mem_rd === 1'b1) mem_rdata <= mem[mem_addr];
      end
   end

   // Transaction-level reference: who owns the memory this cycle, and what each port must see.
   typedef enum logic [1:0] {NONE, CPU, LDR} who_t;

   who_t          m_gnt = NONE;
   logic          m_wr = 1'b0;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_wdata = '0;
   int            m_starve = 0;
   logic          m_cpu_rv = 1'b0, m_ldr_rv = 1'b0;
   logic [DW-1:0] m_cpu_rd = '0, m_ldr_rd = '0;
   logic [DW-1:0] ref_mem [32];

   always @(posedge clk) begin : model
      who_t win;
      int   s;
      started <= 1'b1;
      if (!started) begin
         for (int i = 0; i < 32; i++) ref_mem[i] <= init_val(i);
      end
      // A write already strobed to memory commits even if reset arrives at that edge.
      if (started && m_gnt != NONE && m_wr) ref_mem[m_addr] <= m_wdata;
      if (!rst_) begin
         m_gnt    <= NONE;
         m_starve <= 0;
         m_cpu_rv <= 1'b0;
         m_ldr_rv <= 1'b0;
         m_cpu_rd <= '0;
         m_ldr_rd <= '0;
      end else begin
         m_cpu_rv <= (m_gnt == CPU) && !m_wr;
         m_ldr_rv <= (m_gnt == LDR) && !m_wr;
         if (m_gnt == CPU && !m_wr) m_cpu_rd <= ref_mem[m_addr];
         if (m_gnt == LDR && !m_wr) m_ldr_rd <= ref_mem[m_addr];

         win = NONE;
         if (cpu_req && ldr_req) win = (m_starve == LIMIT) ? LDR : CPU;
         else if (cpu_req)       win = CPU;
         else if (ldr_req)       win = LDR;

         s = m_starve;
         if (!ldr_req || win == LDR) s = 0;
         else if (win == CPU)        s = (s + 1 > LIMIT) ? LIMIT : s + 1;
         m_starve <= s;
         m_gnt    <= win;

         if (win == CPU) begin
            m_wr <= cpu_wr; m_addr <= cpu_addr; m_wdata <= cpu_wdata;
         end else if (win == LDR) begin
            m_wr <= ldr_wr; m_addr <= ldr_addr; m_wdata <= ldr_wdata;
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         check("cpu_gnt",    cpu_gnt,    m_gnt == CPU);
         check("ldr_gnt",    ldr_gnt,    m_gnt == LDR);
         check("cpu_stall",  cpu_stall,  cpu_req && m_gnt != CPU);
         check("mem_rd",     mem_rd,     m_gnt != NONE && !m_wr);
         check("mem_wr",     mem_wr,     m_gnt != NONE && m_wr);
         check("cpu_rvalid", cpu_rvalid, m_cpu_rv);
         check("ldr_rvalid", ldr_rvalid, m_ldr_rv);
         check("cpu_rdata",  cpu_rdata,  m_cpu_rd);
         check("ldr_rdata",  ldr_rdata,  m_ldr_rd);
         if (m_gnt != NONE) begin
            check("mem_addr",  mem_addr,  m_addr);
            check("mem_wdata", mem_wdata, m_wdata);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [AW-1:0] pick_addr();
      return ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 3));
   endfunction

   initial begin
      // Reset held with both requests pending
      cpu_req = 1'b1; cpu_addr = 5'd1; ldr_req = 1'b1; ldr_addr = 5'd2;
      repeat (3) tick();
      @(negedge clk);
      check("rst_cpu_gnt",    cpu_gnt,    0);
      check("rst_ldr_gnt",    ldr_gnt,    0);
      check("rst_mem_rd",     mem_rd,     0);
      check("rst_mem_wr",     mem_wr,     0);
      check("rst_mem_addr",   mem_addr,   0);
      check("rst_mem_wdata",  mem_wdata,  0);
      check("rst_cpu_rvalid", cpu_rvalid, 0);
      check("rst_ldr_rvalid", ldr_rvalid, 0);
      check("rst_cpu_rdata",  cpu_rdata,  0);
      check("rst_ldr_rdata",  ldr_rdata,  0);
      rst_ = 1'b1;
      tick();
      cpu_req = 1'b0; ldr_req = 1'b0;
      @(negedge clk);
      check("first_gnt_cpu", cpu_gnt, 1);
      check("first_gnt_ldr", ldr_gnt, 0);
      repeat (3) tick();

      // CPU read of address 5
      cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 5'd5;
      tick();
      cpu_req = 1'b0;
      @(negedge clk);
      check("rd5_gnt",  cpu_gnt,  1);
      check("rd5_mrd",  mem_rd,   1);
      check("rd5_mwr",  mem_wr,   0);
      check("rd5_addr", mem_addr, 5);
      tick();
      @(negedge clk);
      check("rd5_rvalid",     cpu_rvalid, 1);
      check("rd5_rdata",      cpu_rdata,  8'hA7);
      check("rd5_ldr_rvalid", ldr_rvalid, 0);
      repeat (2) tick();

      // Loader write to 31 followed by a CPU read of 31
      ldr_req = 1'b1; ldr_wr = 1'b1; ldr_addr = 5'd31; ldr_wdata = 8'h3C;
      tick();
      ldr_req = 1'b0; cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 5'd31;
      @(negedge clk);
      check("wr31_gnt",   ldr_gnt,   1);
      check("wr31_mwr",   mem_wr,    1);
      check("wr31_addr",  mem_addr,  31);
      check("wr31_wdata", mem_wdata, 8'h3C);
      tick();
      cpu_req = 1'b0;
      @(negedge clk);
      check("rd31_gnt", cpu_gnt, 1);
      check("rd31_mrd", mem_rd,  1);
      tick();
      @(negedge clk);
      check("rd31_rvalid", cpu_rvalid, 1);
      check("rd31_rdata",  cpu_rdata,  8'h3C);
      repeat (2) tick();

      // Both requests held: four CPU grants, then one loader grant, repeating
      cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 5'd2;
      ldr_req = 1'b1; ldr_wr = 1'b0; ldr_addr = 5'd3;
      for (int i = 0; i < 10; i++) begin
         tick();
         @(negedge clk);
         check($sformatf("starve_cpu_%0d", i),   cpu_gnt,   (i % 5) != 4);
         check($sformatf("starve_ldr_%0d", i),   ldr_gnt,   (i % 5) == 4);
         check($sformatf("starve_stall_%0d", i), cpu_stall, (i % 5) == 4);
      end
      cpu_req = 1'b0; ldr_req = 1'b0;
      repeat (3) tick();

      // Simultaneous single requests
      cpu_req = 1'b1; cpu_addr = 5'd7; ldr_req = 1'b1; ldr_addr = 5'd8;
      tick();
      cpu_req = 1'b0;
      @(negedge clk);
      check("sim_cpu_gnt", cpu_gnt,   1);
      check("sim_ldr_gnt", ldr_gnt,   0);
      check("sim_stall0",  cpu_stall, 0);
      tick();
      ldr_req = 1'b0;
      @(negedge clk);
      check("sim_ldr_gnt1", ldr_gnt,   1);
      check("sim_stall1",   cpu_stall, 0);
      tick();
      @(negedge clk);
      check("sim_ldr_once", ldr_gnt, 0);
      repeat (2) tick();

      // Reset during a granted CPU read drops its response
      cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 5'd5;
      tick();
      cpu_req = 1'b0; rst_ = 1'b0;
      @(negedge clk);
      check("abort_gnt", cpu_gnt, 1);
      tick();
      rst_ = 1'b1;
      @(negedge clk);
      check("abort_rvalid0", cpu_rvalid, 0);
      check("abort_idle",    cpu_gnt | ldr_gnt | mem_rd | mem_wr, 0);
      tick();
      @(negedge clk);
      check("abort_rvalid1", cpu_rvalid, 0);

      // Randomized traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         tick();
         rst_ = ($urandom_range(0, 199) != 0);
         if (!cpu_req || m_gnt == CPU) begin
            cpu_req   = ($urandom_range(0, 99) < 55);
            cpu_wr    = 1'($urandom_range(0, 1));
            cpu_addr  = pick_addr();
            cpu_wdata = DW'($urandom);
         end
         if (!ldr_req || m_gnt == LDR) begin
            ldr_req   = ($urandom_range(0, 99) < 60);
            ldr_wr    = 1'($urandom_range(0, 1));
            ldr_addr  = pick_addr();
            ldr_wdata = DW'($urandom);
         end
      end
      rst_ = 1'b1; cpu_req = 1'b0; ldr_req = 1'b0;
      repeat (4) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
